// File: rtl/oddr_serializer_pkg.sv
// Shared definitions for the parallel-to-DDR serializer: bit-order encodings,
// default idle fill and the width helpers for the beat and slip counters.
package oddr_serializer_pkg;

    // Bit-order encodings for the LSB_FIRST parameter.
    localparam bit ORDER_LSB_FIRST = 1'b1;
    localparam bit ORDER_MSB_FIRST = 1'b0;

    // Fill bit used to build the default idle pattern.
    localparam bit IDLE_FILL_BIT = 1'b0;

    // Width of the beat index: one beat per bit pair, never narrower than 1 bit.
    function automatic int beat_w(input int ratio);
        return (ratio / 2 > 1) ? $clog2(ratio / 2) : 1;
    endfunction

    // Width of the bit-slip counter, which counts 0..ratio-1.
    function automatic int slip_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/oddr_serializer_if.sv
// Word input bus of the serializer.
// Handshake: a word transfers on a rising clk edge where s_valid && s_ready;
// s_data must stay stable while s_valid is high until that edge, and s_ready
// never depends on s_valid.
interface oddr_serializer_if #(
    parameter int LANES = 4,
    parameter int RATIO = 8
);
    logic [LANES*RATIO-1:0] s_data;
    logic                   s_valid;
    logic                   s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/oddr_serializer_lane.sv
// One serial lane: keeps the last two words in transmit order and selects the
// d1/d2 pair for the coming beat, offset backwards by the current slip.
module oddr_serializer_lane
    import oddr_serializer_pkg::*;
#(
    parameter int RATIO     = 8,
    parameter bit LSB_FIRST = ORDER_LSB_FIRST,
    parameter int BEAT_W    = 2,
    parameter int SLIP_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [RATIO-1:0]  load_word,
    input  logic [BEAT_W-1:0] beat,
    input  logic [SLIP_W-1:0] slip,
    output logic              d1,
    output logic              d2
);
    localparam int HIST_W = 2 * RATIO;
    localparam int IDX_W  = $clog2(HIST_W);

    logic [RATIO-1:0]  ord_word;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic [IDX_W-1:0]  idx1, idx2;
    logic              d1_q, d1_d, d2_q, d2_d;

    // Reorder the word so that ord_word[j] is the j-th bit to go on the wire.
    always_comb begin
        ord_word = '0;
        for (int j = 0; j < RATIO; j++) begin
            ord_word[j] = (LSB_FIRST == ORDER_LSB_FIRST) ? load_word[j] : load_word[RATIO-1-j];
        end
    end

    // Upper half holds the current word, lower half the previous one; a slip
    // of s bits reaches s positions back into the previous word.
    always_comb begin
        hist_d = hist_q;
        if (load) begin
            hist_d = {ord_word, hist_q[HIST_W-1 -: RATIO]};
        end
        idx1 = IDX_W'(RATIO + 2 * int'(beat) - int'(slip));
        idx2 = IDX_W'(RATIO + 2 * int'(beat) + 1 - int'(slip));
        d1_d = hist_d[idx1];
        d2_d = hist_d[idx2];
    end

    // History and output pair registers; reset drops any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            d1_q   <= 1'b0;
            d2_q   <= 1'b0;
        end else begin
            hist_q <= hist_d;
            d1_q   <= d1_d;
            d2_q   <= d2_d;
        end
    end

    assign d1 = d1_q;
    assign d2 = d2_q;

endmodule

// File: rtl/oddr_serializer.sv
// Parallel-to-DDR serializer top: free-running beat counter for word framing,
// input handshake, status flags and LANES lane instances.
// Optional bit-slip (input port bitslip) is built when ODDR_SERIALIZER_BITSLIP_EN is defined.
module oddr_serializer
    import oddr_serializer_pkg::*;
#(
    parameter int               LANES        = 4,
    parameter int               RATIO        = 8,
    parameter logic [RATIO-1:0] IDLE_PATTERN = {RATIO{IDLE_FILL_BIT}},
    parameter bit               LSB_FIRST    = ORDER_LSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ODDR_SERIALIZER_BITSLIP_EN
    input  logic             bitslip,
`endif
    oddr_serializer_if.slave s_if,
    output logic [LANES-1:0] d1,
    output logic [LANES-1:0] d2,
    output logic             word_start,
    output logic             busy,
    output logic             underrun
);
    localparam int                BEATS     = RATIO / 2;
    localparam int                BEAT_W    = beat_w(RATIO);
    localparam int                SLIP_W    = slip_w(RATIO);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              busy_q, busy_d;
    logic              word_start_q, word_start_d;
    logic              underrun_q, underrun_d;
    logic              boundary, accept;
    logic [SLIP_W-1:0] slip_eff;

    // The last beat of a word is the only cycle a new word may be taken.
    assign boundary    = (beat_cnt_q == LAST_BEAT);
    assign s_if.s_ready = boundary;
    assign accept      = s_if.s_valid && boundary;

    // Framing and status: the counter never stops, so idle gaps keep alignment.
    always_comb begin
        beat_cnt_d   = boundary ? '0 : beat_cnt_q + BEAT_W'(1);
        busy_d       = boundary ? accept : busy_q;
        word_start_d = accept;
        underrun_d   = boundary && !s_if.s_valid && busy_q;
    end

    // Framing/status registers; reset parks the counter on a boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q   <= LAST_BEAT;
            busy_q       <= 1'b0;
            word_start_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            beat_cnt_q   <= beat_cnt_d;
            busy_q       <= busy_d;
            word_start_q <= word_start_d;
            underrun_q   <= underrun_d;
        end
    end

`ifdef ODDR_SERIALIZER_BITSLIP_EN
    localparam logic [SLIP_W-1:0] LAST_SLIP = SLIP_W'(RATIO - 1);

    logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
    logic [SLIP_W-1:0] slip_eff_q, slip_eff_d;

    // Slip requests accumulate at once but are applied to the lanes only
    // from the next boundary, so a word never changes offset mid-flight.
    always_comb begin
        slip_cnt_d = slip_cnt_q;
        if (bitslip) begin
            slip_cnt_d = (slip_cnt_q == LAST_SLIP) ? '0 : slip_cnt_q + SLIP_W'(1);
        end
        slip_eff_d = boundary ? slip_cnt_q : slip_eff_q;
    end

    // Requested and applied slip registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slip_cnt_q <= '0;
            slip_eff_q <= '0;
        end else begin
            slip_cnt_q <= slip_cnt_d;
            slip_eff_q <= slip_eff_d;
        end
    end

    assign slip_eff = slip_eff_d;
`else
    assign slip_eff = '0;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        oddr_serializer_lane #(
            .RATIO     (RATIO),
            .LSB_FIRST (LSB_FIRST),
            .BEAT_W    (BEAT_W),
            .SLIP_W    (SLIP_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      (boundary),
            .load_word (accept ? s_if.s_data[l*RATIO +: RATIO] : IDLE_PATTERN),
            .beat      (beat_cnt_d),
            .slip      (slip_eff),
            .d1        (d1[l]),
            .d2        (d2[l])
        );
    end

    assign word_start = word_start_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_oddr_serializer.sv
// Bench for oddr_serializer: three instances (LSB-first 8:1 with idle 0x0F,
// MSB-first 8:1 with zero idle, 4-lane 2:1) checked cycle by cycle against
// expected beats queued when each word boundary is seen.
`timescale 1ns/1ps
module tb_oddr_serializer;

    localparam int NDUT = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    oddr_serializer_if #(.LANES(1), .RATIO(8)) if_a ();
    oddr_serializer_if #(.LANES(1), .RATIO(8)) if_b ();
    oddr_serializer_if #(.LANES(4), .RATIO(2)) if_c ();

    logic       a_d1, a_d2, a_ws, a_busy, a_ur;
    logic       b_d1, b_d2, b_ws, b_busy, b_ur;
    logic [3:0] c_d1, c_d2;
    logic       c_ws, c_busy, c_ur;

`ifdef ODDR_SERIALIZER_BITSLIP_EN
    logic bitslip_c   = 1'b0;
    logic bitslip_off = 1'b0;
`endif

    oddr_serializer #(.LANES(1), .RATIO(8), .IDLE_PATTERN(8'h0F), .LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst),
`ifdef ODDR_SERIALIZER_BITSLIP_EN
        .bitslip(bitslip_off),
`endif
        .s_if(if_a), .d1(a_d1), .d2(a_d2), .word_start(a_ws), .busy(a_busy), .underrun(a_ur)
    );

    oddr_serializer #(.LANES(1), .RATIO(8), .IDLE_PATTERN(8'h00), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst),
`ifdef ODDR_SERIALIZER_BITSLIP_EN
        .bitslip(bitslip_off),
`endif
        .s_if(if_b), .d1(b_d1), .d2(b_d2), .word_start(b_ws), .busy(b_busy), .underrun(b_ur)
    );

    oddr_serializer #(.LANES(4), .RATIO(2), .IDLE_PATTERN(2'b00), .LSB_FIRST(1'b1)) dut_c (
        .clk(clk), .rst(rst),
`ifdef ODDR_SERIALIZER_BITSLIP_EN
        .bitslip(bitslip_c),
`endif
        .s_if(if_c), .d1(c_d1), .d2(c_d2), .word_start(c_ws), .busy(c_busy), .underrun(c_ur)
    );

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    // Entry: [10]=word_start [9]=busy [8]=underrun [7:4]=d1 lanes [3:0]=d2 lanes
    int         ratio_m [NDUT] = '{8, 8, 2};
    int         lanes_m [NDUT] = '{1, 1, 4};
    bit         lsb_m   [NDUT] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] idle_m  [NDUT] = '{8'h0F, 8'h00, 8'h00};
    int         beat_m  [NDUT];
    bit         busy_m  [NDUT];
    int         acc_cnt [NDUT] = '{0, 0, 0};
    logic [7:0] prev_o  [NDUT][4];
    int         slip_cnt_m = 0;

    logic [10:0] exp_a_q[$];
    logic [10:0] exp_b_q[$];
    logic [10:0] exp_c_q[$];
    logic [10:0] mon_e;

    task automatic reset_model();
        for (int id = 0; id < NDUT; id++) begin
            beat_m[id] = ratio_m[id] / 2 - 1;
            busy_m[id] = 1'b0;
            for (int l = 0; l < 4; l++) prev_o[id][l] = 8'h00;
        end
        slip_cnt_m = 0;
        exp_a_q.delete();
        exp_b_q.delete();
        exp_c_q.delete();
    endtask

    // Applied at each rising edge with the inputs as they were before it.
    task automatic model_edge(input int id, input logic valid, input logic [31:0] data, input int slip);
        int          r;
        int          b;
        bit          acc;
        bit          ur;
        logic [7:0]  w;
        logic [7:0]  o;
        logic [15:0] hist [4];
        logic [10:0] e;
        r = ratio_m[id];
        b = r / 2;
        if (beat_m[id] != b - 1) begin
            beat_m[id]++;
            return;
        end
        acc = valid;
        ur  = busy_m[id] && !valid;
        for (int l = 0; l < 4; l++) hist[l] = 16'h0;
        for (int l = 0; l < lanes_m[id]; l++) begin
            w = 8'h00;
            o = 8'h00;
            for (int j = 0; j < r; j++) w[j] = acc ? data[l*r + j] : idle_m[id][j];
            for (int j = 0; j < r; j++) o[j] = lsb_m[id] ? w[j] : w[r-1-j];
            for (int j = 0; j < r; j++) begin
                hist[l][j]     = prev_o[id][l][j];
                hist[l][r + j] = o[j];
            end
            prev_o[id][l] = o;
        end
        for (int k = 0; k < b; k++) begin
            e = 11'h0;
            e[10] = acc && (k == 0);
            e[9]  = acc;
            e[8]  = ur && (k == 0);
            for (int l = 0; l < lanes_m[id]; l++) begin
                e[4 + l] = hist[l][r + 2*k - slip];
                e[l]     = hist[l][r + 2*k + 1 - slip];
            end
            case (id)
                0:       exp_a_q.push_back(e);
                1:       exp_b_q.push_back(e);
                default: exp_c_q.push_back(e);
            endcase
        end
        busy_m[id] = acc;
        if (acc) acc_cnt[id]++;
        beat_m[id] = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            reset_model();
        end else begin
            model_edge(0, if_a.s_valid, 32'(if_a.s_data), 0);
            model_edge(1, if_b.s_valid, 32'(if_b.s_data), 0);
`ifdef ODDR_SERIALIZER_BITSLIP_EN
            model_edge(2, if_c.s_valid, 32'(if_c.s_data), slip_cnt_m);
            if (bitslip_c) slip_cnt_m = (slip_cnt_m + 1) % ratio_m[2];
`else
            model_edge(2, if_c.s_valid, 32'(if_c.s_data), 0);
`endif
        end
    end

    // Monitor: outputs are registered, so compare on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("a_ready", 32'(if_a.s_ready), 32'(beat_m[0] == ratio_m[0] / 2 - 1));
            check("b_ready", 32'(if_b.s_ready), 32'(beat_m[1] == ratio_m[1] / 2 - 1));
            check("c_ready", 32'(if_c.s_ready), 32'(beat_m[2] == ratio_m[2] / 2 - 1));
            if (exp_a_q.size() > 0) begin
                mon_e = exp_a_q.pop_front();
                check("a_out", 32'({a_ws, a_busy, a_ur, 3'b000, a_d1, 3'b000, a_d2}), 32'(mon_e));
            end
            if (exp_b_q.size() > 0) begin
                mon_e = exp_b_q.pop_front();
                check("b_out", 32'({b_ws, b_busy, b_ur, 3'b000, b_d1, 3'b000, b_d2}), 32'(mon_e));
            end
            if (exp_c_q.size() > 0) begin
                mon_e = exp_c_q.pop_front();
                check("c_out", 32'({c_ws, c_busy, c_ur, c_d1, c_d2}), 32'(mon_e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; holds the word until the model sees it taken.
    task automatic send(input int id, input logic [31:0] data);
        int start;
        bit got;
        start = acc_cnt[id];
        got   = 1'b0;
        case (id)
            0: begin if_a.s_data = data[7:0]; if_a.s_valid = 1'b1; end
            1: begin if_b.s_data = data[7:0]; if_b.s_valid = 1'b1; end
            default: begin if_c.s_data = data[7:0]; if_c.s_valid = 1'b1; end
        endcase
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (acc_cnt[id] != start) got = 1'b1;
        end
        if (!got) check("accept_wait", 32'(acc_cnt[id] - start), 32'd1);
    endtask

    task automatic idle(input int id);
        case (id)
            0:       if_a.s_valid = 1'b0;
            1:       if_b.s_valid = 1'b0;
            default: if_c.s_valid = 1'b0;
        endcase
    endtask

    // ---------------- stimulus ----------------
    initial begin
        if_a.s_valid = 1'b0; if_a.s_data = '0;
        if_b.s_valid = 1'b0; if_b.s_data = '0;
        if_c.s_valid = 1'b0; if_c.s_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_a_d",     32'({a_d1, a_d2}), 32'd0);
        check("rst_a_flags", 32'({a_ws, a_busy, a_ur}), 32'd0);
        check("rst_a_ready", 32'(if_a.s_ready), 32'd1);
        check("rst_b_d",     32'({b_d1, b_d2}), 32'd0);
        check("rst_b_flags", 32'({b_ws, b_busy, b_ur}), 32'd0);
        check("rst_c_d",     32'({c_d1, c_d2}), 32'd0);
        check("rst_c_flags", 32'({c_ws, c_busy, c_ur}), 32'd0);
        check("rst_c_ready", 32'(if_c.s_ready), 32'd1);
        rst = 1'b0;

        // Reference words back-to-back, then idle to provoke an underrun.
        fork
            begin send(0, 32'hA5); send(0, 32'h3C); idle(0); end
            begin send(1, 32'hA5); send(1, 32'hC3); idle(1); end
        join
        repeat (12) @(negedge clk);

        // Asynchronous reset while beat 2 of a word is on the pins.
        send(0, 32'h5A);
        idle(0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_d",     32'({a_d1, a_d2}), 32'd0);
        check("mid_rst_flags", 32'({a_ws, a_busy, a_ur}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_ready", 32'(if_a.s_ready), 32'd1);
        send(0, 32'h96);
        idle(0);
        repeat (6) @(negedge clk);

        // Random words with random gaps on the 8:1 lanes, random valid on the 2:1 lanes.
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    send(0, 32'($urandom_range(0, 255)));
                    if ($urandom_range(0, 1) == 1) begin
                        idle(0);
                        repeat ($urandom_range(1, 6)) @(negedge clk);
                    end
                end
                idle(0);
            end
            begin
                for (int n = 0; n < 8; n++) send(1, 32'($urandom_range(0, 255)));
                idle(1);
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    if_c.s_valid = 1'($urandom_range(0, 1));
                    if_c.s_data  = 8'($urandom());
                    @(negedge clk);
                end
                idle(2);
            end
        join

`ifdef ODDR_SERIALIZER_BITSLIP_EN
        // Continuous stream with isolated and consecutive slip pulses.
        if_c.s_valid = 1'b1;
        for (int n = 0; n < 30; n++) begin
            if_c.s_data = 8'($urandom());
            bitslip_c   = (n == 5 || n == 15 || n == 16);
            @(negedge clk);
        end
        bitslip_c = 1'b0;
        idle(2);
`endif

        repeat (6) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
